// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the simple RISC machine bus.
// Serves word-addressed reads and writes to an on-chip RAM, an LED output
// register and a synchronized switch port. Reads return data one cycle after
// the address is presented. Illegal accesses are captured in a sticky error flag.
module mem_responder #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    RAM_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR   = 'h100,
  parameter logic [ADDR_WIDTH-1:0] SW_ADDR    = 'h140
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_cmd,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic [7:0]            SW,
  output logic [7:0]            LEDR,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  localparam int                    RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] RAM_LIMIT = ADDR_WIDTH'(RAM_WORDS);

  // Word storage; contents survive reset (the program image lives here).
  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];

  logic [DATA_WIDTH-1:0] read_data_reg, read_data_next;
  logic [7:0]            led_reg;
  logic [7:0]            sw_s1_reg, sw_s2_reg;
  logic                  bus_err_reg;
  logic [ADDR_WIDTH-1:0] err_addr_reg;

  logic              ram_hit, led_hit, sw_hit;
  logic              is_read, is_write, access_err;
  logic [RAM_AW-1:0] ram_idx;

  // Address and command decode for the current cycle.
  always_comb begin
    ram_hit    = (mem_addr < RAM_LIMIT);
    led_hit    = (mem_addr == LED_ADDR);
    sw_hit     = (mem_addr == SW_ADDR);
    ram_idx    = mem_addr[RAM_AW-1:0];
    is_read    = (mem_cmd == CMD_READ);
    is_write   = (mem_cmd == CMD_WRITE);
    // Reads of unmapped space, writes to anything but RAM/LED, and the
    // reserved command encoding are all illegal.
    access_err = (mem_cmd == CMD_ILL)
               | (is_read  & ~ram_hit & ~led_hit & ~sw_hit)
               | (is_write & ~ram_hit & ~led_hit);
  end

  // Read data mux; anything other than a mapped read returns zero so the
  // register never holds stale data.
  always_comb begin
    read_data_next = '0;
    if (is_read) begin
      if (ram_hit)      read_data_next = ram[ram_idx];
      else if (led_hit) read_data_next = DATA_WIDTH'(led_reg);
      else if (sw_hit)  read_data_next = DATA_WIDTH'(sw_s2_reg);
    end
  end

  // RAM write port; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && is_write && ram_hit)
      ram[ram_idx] <= write_data;
  end

  // Registered read result, LED register and switch synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_reg <= '0;
      led_reg       <= '0;
      sw_s1_reg     <= '0;
      sw_s2_reg     <= '0;
    end else begin
      read_data_reg <= read_data_next;
      sw_s1_reg     <= SW;
      sw_s2_reg     <= sw_s1_reg;
      if (is_write && led_hit)
        led_reg <= write_data[7:0];
    end
  end

  // Sticky error capture: only the first illegal access after reset is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_reg  <= 1'b0;
      err_addr_reg <= '0;
    end else if (access_err && !bus_err_reg) begin
      bus_err_reg  <= 1'b1;
      err_addr_reg <= mem_addr;
    end
  end

  assign read_data = read_data_reg;
  assign LEDR      = led_reg;
  assign bus_err   = bus_err_reg;
  assign err_addr  = err_addr_reg;

endmodule
